// File: rtl/uart_pkg.sv
// Shared UART TX/RX definitions: default frame width, serializer state type and
// bit-counter width helper.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2
  } ser_state_t;

  // One extra bit so the counter can hold DATA_WIDTH itself as its terminal value.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/ser_bit_counter.sv
// Saturating frame bit counter with synchronous clear; term flags count == TERMINAL.
// Shared by the TX serializer and the RX deserializer.
module ser_bit_counter #(
  parameter int TERMINAL = 8,
  parameter int CNT_W    = $clog2(TERMINAL) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  assign term = (count == CNT_W'(TERMINAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serializer.sv
// UART TX data serializer: loads a byte when idle, shifts it out one bit per enabled
// clock and pulses done with the last bit. Define SERIALIZER_MSB_FIRST_EN for MSB-first.
module serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  input  logic                  busy,
  input  logic                  enable,
  output logic                  data_out,
  output logic                  done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  ser_state_t            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  out_bit;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  cnt_term;
  logic                  cnt_inc;
  logic                  cnt_clr;
  logic                  load_ok;
  logic                  last_bit;

`ifdef SERIALIZER_MSB_FIRST_EN
  assign out_bit   = shift_reg[DATA_WIDTH-1];
  assign shift_nxt = {shift_reg[DATA_WIDTH-2:0], 1'b0};
`else
  assign out_bit   = shift_reg[0];
  assign shift_nxt = {1'b0, shift_reg[DATA_WIDTH-1:1]};
`endif

  assign load_ok  = valid && !busy;
  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign cnt_inc  = enable && ((state == LOADED) || ((state == SHIFT) && !cnt_term));
  assign cnt_clr  = (state == SHIFT) && cnt_term;

  ser_bit_counter #(
    .TERMINAL (DATA_WIDTH),
    .CNT_W    (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (bit_cnt),
    .term  (cnt_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      data_out  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          data_out <= 1'b0;
          if (load_ok) begin
            shift_reg <= data_in;
            state     <= LOADED;
          end
        end
        LOADED: begin
          if (enable) begin
            data_out  <= out_bit;
            shift_reg <= shift_nxt;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Counter at terminal means done is high now: return to idle, allowing a
          // back-to-back load on this same edge.
          if (cnt_term) begin
            data_out <= 1'b0;
            state    <= IDLE;
            if (load_ok) begin
              shift_reg <= data_in;
              state     <= LOADED;
            end
          end else if (enable) begin
            data_out  <= out_bit;
            shift_reg <= shift_nxt;
            done      <= last_bit;
          end
        end
        default: begin
          data_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed scenarios plus randomized chained
// frames checked against a bit-index reference model.
module tb_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         valid = 1'b0;
  logic         busy = 1'b0;
  logic         enable = 1'b0;
  logic         data_out;
  logic         done;

  int checks = 0;
  int failures = 0;

  serializer #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid    (valid),
    .busy     (busy),
    .enable   (enable),
    .data_out (data_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Bit transmitted on the (i+1)th enabled edge of a frame carrying word w.
  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef SERIALIZER_MSB_FIRST_EN
    return w[W-1-i];
`else
    return w[i];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    valid = 1'b1; data_in = 8'h4B; enable = 1'b1; busy = 1'b0;
    #1;
    checks++;
    if (data_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: data_out=%b done=%b required 0 0", data_out, done);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (data_out !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: data_out=%b done=%b required 0 0", data_out, done);
      end
    end
    rst = 1'b0; enable = 1'b0;
    tick();
    valid = 1'b0;
    checks++;
    if (data_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_loaded: data_out=%b done=%b required 0 0", data_out, done);
    end
    enable = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if (data_out !== exp_bit(8'h4B, i) || done !== (i == W - 1)) begin
        failures++;
        $display("FAIL reset_frame bit%0d: data_out=%b done=%b required %b %b",
                 i, data_out, done, exp_bit(8'h4B, i), (i == W - 1));
      end
    end
    tick();
    checks++;
    if (data_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_idle: data_out=%b done=%b required 0 0", data_out, done);
    end
    enable = 1'b0;
  endtask

  task automatic test_basic();
    valid = 1'b1; busy = 1'b0; data_in = 8'h4B; enable = 1'b0;
    tick();
    valid = 1'b0; busy = 1'b1; enable = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if (data_out !== exp_bit(8'h4B, i) || done !== (i == W - 1)) begin
        failures++;
        $display("FAIL basic bit%0d: data_out=%b done=%b required %b %b",
                 i, data_out, done, exp_bit(8'h4B, i), (i == W - 1));
      end
    end
    tick();
    checks++;
    if (data_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: data_out=%b done=%b required 0 0", data_out, done);
    end
    enable = 1'b0; busy = 1'b0;
  endtask

  task automatic test_load_block();
    busy = 1'b1; valid = 1'b1; data_in = 8'hFF; enable = 1'b0;
    tick();
    tick();
    busy = 1'b0; valid = 1'b0; enable = 1'b1;
    for (int c = 0; c < W + 2; c++) begin
      tick();
      checks++;
      if (data_out !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL load_block cyc%0d: data_out=%b done=%b required 0 0", c, data_out, done);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_no_overwrite();
    valid = 1'b1; busy = 1'b0; data_in = 8'hA5; enable = 1'b0;
    tick();
    data_in = 8'h3C;
    tick();
    tick();
    valid = 1'b0; enable = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if (data_out !== exp_bit(8'hA5, i) || done !== (i == W - 1)) begin
        failures++;
        $display("FAIL no_overwrite bit%0d: data_out=%b done=%b required %b %b",
                 i, data_out, done, exp_bit(8'hA5, i), (i == W - 1));
      end
    end
    tick();
    enable = 1'b0;
  endtask

  task automatic test_pause();
    valid = 1'b1; busy = 1'b0; data_in = 8'hF0; enable = 1'b0;
    tick();
    valid = 1'b0; enable = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if (data_out !== exp_bit(8'hF0, i) || done !== (i == W - 1)) begin
        failures++;
        $display("FAIL pause bit%0d: data_out=%b done=%b required %b %b",
                 i, data_out, done, exp_bit(8'hF0, i), (i == W - 1));
      end
      if (i == 3) begin
        enable = 1'b0;
        for (int p = 0; p < 3; p++) begin
          tick();
          checks++;
          if (data_out !== exp_bit(8'hF0, 3) || done !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold cyc%0d: data_out=%b done=%b required %b 0",
                     p, data_out, done, exp_bit(8'hF0, 3));
          end
        end
        enable = 1'b1;
      end
    end
    tick();
    checks++;
    if (data_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL pause_idle: data_out=%b done=%b required 0 0", data_out, done);
    end
    enable = 1'b0;
  endtask

  task automatic test_abort();
    valid = 1'b1; busy = 1'b0; data_in = 8'h4B; enable = 1'b0;
    tick();
    valid = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: data_out=%b done=%b required 0 0", data_out, done);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      tick();
      checks++;
      if (data_out !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cyc%0d: data_out=%b done=%b required 0 0", c, data_out, done);
      end
    end
    enable = 1'b0; valid = 1'b1; data_in = 8'h81;
    tick();
    valid = 1'b0; enable = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if (data_out !== exp_bit(8'h81, i) || done !== (i == W - 1)) begin
        failures++;
        $display("FAIL abort_reload bit%0d: data_out=%b done=%b required %b %b",
                 i, data_out, done, exp_bit(8'h81, i), (i == W - 1));
      end
    end
    tick();
    enable = 1'b0;
  endtask

  // Chained random frames: each new word is loaded on the edge right after done,
  // with random enable gaps and random valid/busy/data noise mid-frame.
  task automatic test_back_to_back();
    logic [W-1:0] word;
    int           k;
    int           budget;
    logic         e;
    word = W'($urandom);
    valid = 1'b1; busy = 1'b0; data_in = word; enable = 1'(($urandom));
    tick();
    for (int f = 0; f < 40; f++) begin
      checks++;
      if (data_out !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL b2b_loaded frame%0d: data_out=%b done=%b required 0 0", f, data_out, done);
      end
      k = 0;
      budget = 0;
      while (k < W && budget < 200) begin
        e = ($urandom_range(0, 3) != 0);
        enable = e;
        valid = 1'(($urandom));
        busy = 1'(($urandom));
        data_in = W'($urandom);
        tick();
        budget++;
        if (e) k++;
        checks++;
        if (data_out !== ((k == 0) ? 1'b0 : exp_bit(word, k - 1)) || done !== (e && k == W)) begin
          failures++;
          $display("FAIL b2b frame%0d edge%0d: data_out=%b done=%b required %b %b", f, k,
                   data_out, done, ((k == 0) ? 1'b0 : exp_bit(word, k - 1)), (e && k == W));
        end
      end
      if (k < W) begin
        checks++;
        failures++;
        $display("FAIL b2b_timeout frame%0d: bits=%0d required %0d", f, k, W);
      end
      word = W'($urandom);
      valid = 1'b1; busy = 1'b0; data_in = word; enable = 1'(($urandom));
      tick();
    end
    valid = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_block();
    test_no_overwrite();
    test_pause();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Transmit-side data serializer for the UART TX path.
- Captures a parallel byte when the transmitter is idle, then shifts it out one bit per clock while enabled, LSB first.
- Pulses done with the final bit so the TX controller can move on to the parity/stop stage.
- Sits between the TX input register and the TX output mux, under control of the TX FSM.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (>=2); bit counter width = $clog2(DATA_WIDTH)+1

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  DATA_WIDTH  parallel data to transmit
- valid  input  1  data_in holds a new word
- busy  input  1  TX FSM is mid-frame; blocks loading
- enable  input  1  shift permission from TX FSM; one bit per clock while high
- data_out  output  1  serial bit (registered)
- done  output  1  one-cycle pulse coincident with the last data bit on data_out

Behaviour:
- Reset (async, rst=1): shift register=0, bit counter=0, state=IDLE, data_out=0, done=0; all hold until rst falls.
- States: IDLE, LOADED, SHIFT.
- IDLE:
  - valid=1 and busy=0 at a rising edge -> shift_reg<=data_in, go to LOADED.
  - valid while busy=1 is ignored.
  - data_out=0.
- LOADED:
  - Further valid/data_in ignored (no overwrite).
  - enable=1 at an edge -> data_out<=shift_reg[0], shift_reg>>=1, counter<=1, go to SHIFT.
- SHIFT:
  - Each edge with enable=1 -> data_out<=next bit, counter+1.
  - enable=0 pauses shifting; data_out, counter and shift_reg hold; done stays 0.
- Bit order: LSB first. Bit i appears on data_out after the (i+1)th enabled edge.
- done:
  - Registered. Goes to 1 on the same edge that places bit DATA_WIDTH-1 on data_out (counter reaches DATA_WIDTH).
  - Stays high exactly one cycle, regardless of enable.
- Edge after done: state=IDLE, counter=0, data_out=0, done=0.
  - Same edge may load a new word if valid=1 and busy=0.
- Latency:
  - Load edge L; earliest first bit at edge L+1.
  - Last bit and done at edge L+DATA_WIDTH (no pauses); idle at L+DATA_WIDTH+1.
- enable in IDLE has no effect.
- busy only gates loading; it does not affect shifting.
- Reset mid-frame aborts immediately with no done pulse.
- The counter never exceeds DATA_WIDTH; no wrap.

Optional Feature:
- Macro SERIALIZER_MSB_FIRST_EN.
- Defined: shift register shifts left and data_out takes shift_reg[DATA_WIDTH-1]; bits leave MSB first. Timing and done are unchanged.
- Undefined (default): LSB-first behaviour as above.

Decomposition:
- Package uart_pkg holds:
  - DATA_WIDTH default constant
  - ser_state_t enum (IDLE, LOADED, SHIFT)
  - counter width constant derived from DATA_WIDTH
- One sub-module is natural: ser_bit_counter (enable/clear, count output, terminal flag at DATA_WIDTH).
  - Used by serializer, reusable by the RX deserializer.

Test Plan:
- Reset: rst=1 with valid=1, data_in=8'h4B -> data_out=0, done=0, no load. After rst falls, valid=1, busy=0 -> loaded at the next edge.
- Basic frame: load 8'h4B, then enable=1, busy=1, valid=0 -> data_out over 8 cycles = 1,1,0,1,0,0,1,0; done=1 only with the 8th bit; next cycle data_out=0, done=0.
- Load blocking: busy=1, valid=1, data_in=8'hFF while idle -> no load; a later enable produces no bits and no done.
- No overwrite: load 8'hA5, then valid=1 with data_in=8'h3C before enable -> serial output is 8'hA5 (1,0,1,0,0,1,0,1).
- Pause: frame 8'hF0, enable dropped for 3 cycles after bit 3 -> data_out holds bit 3 (0); resumes with bit 4 (1); done after 8 enabled edges.
- Abort: rst pulsed after bit 2 of 8'h4B -> data_out=0 and done=0 immediately; no done pulse follows; the next load of 8'h81 transmits cleanly.
